// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the alu_share_arbiter slice: datapath widths,
// operation encodings understood by arithmetic_unit, and the sequencer
// state type.
package alu_share_arbiter_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned OP_W   = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ZERO = 2'b10,
    OP_NEG  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_arithmetic_unit.sv
// arithmetic_unit: combinational 4-bit datapath shared by both requesters.
//   a, b : operands
//   sel  : 00 = a+b, 01 = a-b, 10 = zero, 11 = two's complement of a
//   y    : result modulo 2**DATA_W (carry/borrow discarded)
module arithmetic_unit
  import alu_share_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   sel,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    unique case (sel)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a + ~b + DATA_W'(1);
      OP_ZERO: y = '0;
      OP_NEG:  y = ~a + DATA_W'(1);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sequencer that time-shares one
// arithmetic_unit between two requesters. One operation is in flight at a
// time: IDLE (grant + latch) -> EXEC (compute, register) -> RESP (hold
// result until the owner takes it).
//   clk, rst              : clock, synchronous active-high reset
//   reqN_valid/ready      : operation request handshake, N = 0/1
//   reqN_a/b/op           : operands and operation select
//   rspN_valid/ready      : response handshake
//   rspN_result           : result, zero whenever rspN_valid is low
//   busy                  : high whenever the sequencer is not IDLE
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              busy
);

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic [DATA_W-1:0]   alu_y;
  logic                any_valid;
  logic                win1;

  arithmetic_unit u_alu (
    .a   (a_q),
    .b   (b_q),
    .sel (op_q),
    .y   (alu_y)
  );

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign any_valid = req0_valid | req1_valid;
  assign win1      = req1_valid & (~req0_valid | ~last_q);
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    result_d    = result_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    rsp0_result = '0;
    rsp1_result = '0;

    unique case (state_q)
      ST_IDLE: begin
        // Ready is masked by rst so nothing is accepted on a reset edge.
        if (any_valid && !rst) begin
          req0_ready = ~win1;
          req1_ready = win1;
          owner_d    = win1;
          a_d        = win1 ? req1_a  : req0_a;
          b_d        = win1 ? req1_b  : req0_b;
          op_d       = win1 ? req1_op : req0_op;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = alu_y;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (!owner_q) begin
          rsp0_valid  = 1'b1;
          rsp0_result = result_q;
          if (rsp0_ready) begin
            last_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          rsp1_valid  = 1'b1;
          rsp1_result = result_q;
          if (rsp1_ready) begin
            last_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [3:0] rsp0_result, rsp1_result;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .busy        (busy)
  );

  typedef struct {
    int         port;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from the operation definitions, modulo 16.
  function automatic int ref_alu(input int a, input int b, input int op);
    case (op)
      0:       return (a + b) % 16;
      1:       return (a - b + 16) % 16;
      2:       return 0;
      default: return (16 - a) % 16;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [3:0] a,
                         input logic [3:0] b, input logic [1:0] op);
    if (p == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic clear_inputs;
    set_req(0, 1'b0, 4'd0, 4'd0, 2'd0);
    set_req(1, 1'b0, 4'd0, 4'd0, 2'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    chk("rst_ready", {req1_ready, req0_ready}, 8'd0);
    tick();
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 8'd0);
    chk("rst_ready_hold", {req1_ready, req0_ready}, 8'd0);
    tick();
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic run_vec(input vec_t v);
    set_req(v.port, 1'b1, v.a, v.b, v.op);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    chk("vec_grant", {req1_ready, req0_ready}, (v.port == 0) ? 8'd1 : 8'd2);
    chk("vec_idle_busy", busy, 1'b0);
    tick();
    set_req(v.port, 1'b0, 4'd0, 4'd0, 2'd0);
    @(negedge clk);
    chk("vec_exec_busy", busy, 1'b1);
    chk("vec_exec_rsp", {rsp1_valid, rsp0_valid}, 8'd0);
    tick();
    @(negedge clk);
    chk("vec_rsp_valid", {rsp1_valid, rsp0_valid}, (v.port == 0) ? 8'd1 : 8'd2);
    chk("vec_result", (v.port == 0) ? rsp0_result : rsp1_result, v.exp);
    chk("vec_other_result", (v.port == 0) ? rsp1_result : rsp0_result, 8'd0);
    chk("vec_rsp_busy", busy, 1'b1);
    tick();
    @(negedge clk);
    chk("vec_back_idle", busy, 1'b0);
    tick();
  endtask

  // Random-phase model: transaction-level view of the sequencer.
  bit m_active;
  int m_owner, m_res, m_age, m_last;
  int completions;

  initial begin
    vecs[0] = '{0, 4'd3,  4'd4, 2'b00, 4'd7};
    vecs[1] = '{1, 4'd9,  4'd9, 2'b00, 4'd2};
    vecs[2] = '{1, 4'd2,  4'd5, 2'b01, 4'd13};
    vecs[3] = '{1, 4'd7,  4'd3, 2'b10, 4'd0};
    vecs[4] = '{1, 4'd5,  4'd0, 2'b11, 4'd11};
    vecs[5] = '{0, 4'd0,  4'd1, 2'b01, 4'd15};
    vecs[6] = '{0, 4'd0,  4'd9, 2'b11, 4'd0};
    vecs[7] = '{0, 4'd15, 4'd1, 2'b00, 4'd0};
    vecs[8] = '{1, 4'd8,  4'd7, 2'b11, 4'd8};

    rst = 1'b1;
    clear_inputs();
    tick();
    do_reset();

    // Table-driven single operations.
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Ties from reset alternate 0,1,0,1 and responses go to the granted port.
    do_reset();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set_req(0, 1'b1, 4'd1, 4'd1, 2'b00);
    set_req(1, 1'b1, 4'd3, 4'd0, 2'b11);
    for (int i = 0; i < 4; i++) begin
      int n;
      n = 0;
      @(negedge clk);
      while (!(req0_ready || req1_ready) && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (n >= 10) chk("tie_wait_timeout", 8'd0, 8'd1);
      chk("tie_grant", {req1_ready, req0_ready}, (i % 2 == 0) ? 8'd1 : 8'd2);
      tick();
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("tie_rsp_port", {rsp1_valid, rsp0_valid}, (i % 2 == 0) ? 8'd1 : 8'd2);
      chk("tie_result", (i % 2 == 0) ? rsp0_result : rsp1_result,
          (i % 2 == 0) ? 8'd2 : 8'd13);
      tick();
    end
    clear_inputs();

    // Backpressure on requester 0 while requester 1 waits.
    set_req(0, 1'b1, 4'd6, 4'd2, 2'b01);
    rsp1_ready = 1'b1;
    @(negedge clk);
    chk("bp_grant0", req0_ready, 1'b1);
    tick();
    set_req(0, 1'b0, 4'd0, 4'd0, 2'd0);
    set_req(1, 1'b1, 4'd1, 4'd2, 2'b00);
    @(negedge clk);
    chk("bp_exec_ready1", req1_ready, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp0_valid", rsp0_valid, 1'b1);
      chk("bp_rsp0_result", rsp0_result, 8'd4);
      chk("bp_ready1", req1_ready, 1'b0);
      tick();
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_rsp0_hold", rsp0_valid, 1'b1);
    tick();
    rsp0_ready = 1'b0;
    @(negedge clk);
    chk("bp_grant1", {req1_ready, req0_ready}, 8'd2);
    tick();
    set_req(1, 1'b0, 4'd0, 4'd0, 2'd0);
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("bp_rsp1_valid", rsp1_valid, 1'b1);
    chk("bp_rsp1_result", rsp1_result, 8'd3);
    tick();

    // Reset during EXEC: no response, pointer back to favour requester 0.
    run_vec(vecs[0]);
    set_req(1, 1'b1, 4'd4, 4'd4, 2'b00);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    chk("mr_grant1", req1_ready, 1'b1);
    tick();
    set_req(1, 1'b0, 4'd0, 4'd0, 2'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_busy_exec", busy, 1'b1);
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, 4'd2, 4'd2, 2'b00);
    set_req(1, 1'b1, 4'd5, 4'd5, 2'b00);
    @(negedge clk);
    chk("mr_busy_after", busy, 1'b0);
    chk("mr_no_rsp", {rsp1_valid, rsp0_valid}, 8'd0);
    chk("mr_tie_grant0", {req1_ready, req0_ready}, 8'd1);
    tick();
    clear_inputs();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    chk("mr_exec_no_rsp", {rsp1_valid, rsp0_valid}, 8'd0);
    tick();
    @(negedge clk);
    chk("mr_rsp0", {rsp1_valid, rsp0_valid}, 8'd1);
    chk("mr_rsp0_result", rsp0_result, 8'd4);
    tick();

    // Idle: no requests, stray response readies have no effect.
    clear_inputs();
    for (int i = 0; i < 10; i++) begin
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle_busy", busy, 1'b0);
      chk("idle_ready", {req1_ready, req0_ready}, 8'd0);
      chk("idle_rsp", {rsp1_valid, rsp0_valid}, 8'd0);
      chk("idle_result", {rsp1_result, rsp0_result}, 8'd0);
      tick();
    end

    // Randomized traffic against the transaction-level model.
    do_reset();
    m_active = 1'b0;
    m_last = 1;
    completions = 0;
    begin
      bit hold[2];
      hold[0] = 1'b0;
      hold[1] = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        int w;
        bit v0, v1;
        for (int p = 0; p < 2; p++) begin
          if (!hold[p] && $urandom_range(0, 2) == 0) begin
            hold[p] = 1'b1;
            set_req(p, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)));
          end else if (!hold[p]) begin
            set_req(p, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)));
          end
        end
        rsp0_ready = 1'($urandom_range(0, 1));
        rsp1_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        v0 = req0_valid;
        v1 = req1_valid;
        w = -1;
        if (!m_active) begin
          if (v0 && v1) w = (m_last == 0) ? 1 : 0;
          else if (v0)  w = 0;
          else if (v1)  w = 1;
        end
        chk("rnd_ready", {req1_ready, req0_ready},
            (w == 0) ? 8'd1 : (w == 1) ? 8'd2 : 8'd0);
        chk("rnd_busy", busy, m_active);
        chk("rnd_rsp0_valid", rsp0_valid, m_active && m_age >= 1 && m_owner == 0);
        chk("rnd_rsp1_valid", rsp1_valid, m_active && m_age >= 1 && m_owner == 1);
        chk("rnd_rsp0_result", rsp0_result,
            (m_active && m_age >= 1 && m_owner == 0) ? 8'(m_res) : 8'd0);
        chk("rnd_rsp1_result", rsp1_result,
            (m_active && m_age >= 1 && m_owner == 1) ? 8'(m_res) : 8'd0);
        if (w >= 0) begin
          m_active = 1'b1;
          m_owner = w;
          m_age = 0;
          m_res = (w == 0) ? ref_alu(int'(req0_a), int'(req0_b), int'(req0_op))
                           : ref_alu(int'(req1_a), int'(req1_b), int'(req1_op));
          hold[w] = 1'b0;
        end else if (m_active) begin
          if (m_age >= 1 && ((m_owner == 0) ? rsp0_ready : rsp1_ready)) begin
            m_active = 1'b0;
            m_last = m_owner;
            completions++;
          end else begin
            m_age++;
          end
        end
        tick();
      end
    end
    chk("rnd_progress", 8'(completions > 20), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
